// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants for the VGA sync generator.
// Defaults describe 640x480@60 with an 11-bit coordinate space.
package vga_timing_pkg;

  localparam int unsigned CNT_W   = 11;
  localparam int unsigned CNT_MAX = 2047;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FRONT_DEF   = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BACK_DEF    = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FRONT_DEF   = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BACK_DEF    = 33;
  localparam int unsigned CLK_DIV_DEF   = 2;

  localparam bit SYNC_ACTIVE_LOW  = 1'b0;
  localparam bit SYNC_ACTIVE_HIGH = 1'b1;

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster outputs of the VGA sync generator, grouped for the display pipeline.
interface vga_sync_gen_if;
  import vga_timing_pkg::*;

  logic             pix_tick;
  logic [CNT_W-1:0] countH;
  logic [CNT_W-1:0] countV;
  logic             h_sinc;
  logic             v_sinc;
  logic             video_on;
  logic             frame_start;

  modport master (
    output pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start
  );

  modport slave (
    input pix_tick, countH, countV, h_sinc, v_sinc, video_on, frame_start
  );

endinterface

// File: rtl/vga_axis_cnt.sv
// One raster axis: wrapping position counter plus sync/visible decode.
// Decode looks at the next count so registered outputs line up with the counter.
module vga_axis_cnt
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL      = 800,
  parameter int unsigned VISIBLE    = 640,
  parameter int unsigned SYNC_START = 656,
  parameter int unsigned SYNC_LEN   = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             wrap,
  output logic             in_sync,
  output logic             in_visible
);

  localparam logic [CNT_W-1:0] Last      = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] Vis       = CNT_W'(VISIBLE);
  localparam logic [CNT_W-1:0] SyncFirst = CNT_W'(SYNC_START);
  localparam logic [CNT_W-1:0] SyncLast  = CNT_W'(SYNC_START + SYNC_LEN - 1);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wrap    = (count_q == Last);
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
    in_sync    = (count_d >= SyncFirst) && (count_d <= SyncLast);
    in_visible = (count_d < Vis);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= Last;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel-rate divider, H/V counters and registered
// sync, blanking and frame markers; the single source of raster position.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE   = H_VISIBLE_DEF,
  parameter int unsigned H_FRONT     = H_FRONT_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BACK      = H_BACK_DEF,
  parameter int unsigned V_VISIBLE   = V_VISIBLE_DEF,
  parameter int unsigned V_FRONT     = V_FRONT_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BACK      = V_BACK_DEF,
  parameter int unsigned CLK_DIV     = CLK_DIV_DEF,
  parameter bit          SYNC_ACTIVE = SYNC_ACTIVE_LOW
) (
  input  logic           clk,
  input  logic           reset,
  vga_sync_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DivLast = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > CNT_MAX || V_TOTAL > CNT_MAX || CLK_DIV < 1) begin : g_bad_params
    $error("vga_sync_gen: totals must fit 11 bits and CLK_DIV must be >= 1");
  end

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic             h_wrap, h_in_sync, h_in_vis;
  logic             v_wrap, v_in_sync, v_in_vis;

  // With CLK_DIV=1 div_q is stuck at 0 == DivLast, so every edge ticks.
  assign tick = (div_q == DivLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
    end
  end

  vga_axis_cnt #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_VISIBLE + H_FRONT),
    .SYNC_LEN   (H_SYNC)
  ) u_h_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (tick),
    .count      (vga.countH),
    .wrap       (h_wrap),
    .in_sync    (h_in_sync),
    .in_visible (h_in_vis)
  );

  vga_axis_cnt #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_VISIBLE + V_FRONT),
    .SYNC_LEN   (V_SYNC)
  ) u_v_cnt (
    .clk        (clk),
    .reset      (reset),
    .enable     (tick && h_wrap),
    .count      (vga.countV),
    .wrap       (v_wrap),
    .in_sync    (v_in_sync),
    .in_visible (v_in_vis)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga.pix_tick    <= 1'b0;
      vga.frame_start <= 1'b0;
      vga.h_sinc      <= ~SYNC_ACTIVE;
      vga.v_sinc      <= ~SYNC_ACTIVE;
      vga.video_on    <= 1'b0;
    end else begin
      vga.pix_tick    <= tick;
      vga.frame_start <= tick && h_wrap && v_wrap;
      vga.h_sinc      <= h_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga.v_sinc      <= v_in_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vga.video_on    <= h_in_vis && v_in_vis;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three configurations checked every clk against an
// arithmetic raster model, plus literal spot checks at key raster positions.
module tb_vga_sync_gen;

  typedef struct packed {
    logic        pix_tick;
    logic        frame_start;
    logic        video_on;
    logic        h_sinc;
    logic        v_sinc;
    logic [10:0] h;
    logic [10:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   e = 0;        // rising edges since reset release
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  vga_sync_gen_if vga_a ();
  vga_sync_gen_if vga_b ();
  vga_sync_gen_if vga_c ();

  vga_sync_gen u_dut_a (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_a)
  );

  vga_sync_gen #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .CLK_DIV (1), .SYNC_ACTIVE (1'b1)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_b)
  );

  vga_sync_gen #(
    .H_VISIBLE (16), .H_FRONT (2), .H_SYNC (4), .H_BACK (3),
    .V_VISIBLE (10), .V_FRONT (2), .V_SYNC (2), .V_BACK (3),
    .CLK_DIV (3), .SYNC_ACTIVE (1'b0)
  ) u_dut_c (
    .clk   (clk),
    .reset (reset),
    .vga   (vga_c)
  );

  exp_t act_a, act_b, act_c;
  always_comb act_a = '{vga_a.pix_tick, vga_a.frame_start, vga_a.video_on, vga_a.h_sinc,
                        vga_a.v_sinc, vga_a.countH, vga_a.countV};
  always_comb act_b = '{vga_b.pix_tick, vga_b.frame_start, vga_b.video_on, vga_b.h_sinc,
                        vga_b.v_sinc, vga_b.countH, vga_b.countV};
  always_comb act_c = '{vga_c.pix_tick, vga_c.frame_start, vga_c.video_on, vga_c.h_sinc,
                        vga_c.v_sinc, vga_c.countH, vga_c.countV};

  // Pixel p (1-based tick count) shows raster index p-1 in row-major order.
  function automatic exp_t model(input int ed, input int hv, input int hf, input int hs,
                                 input int hb, input int vv, input int vf, input int vs,
                                 input int vb, input int d, input bit act);
    int   ht = hv + hf + hs + hb;
    int   vt = vv + vf + vs + vb;
    int   p  = ed / d;
    int   h, v, idx;
    exp_t r;
    if (p == 0) begin
      h = ht - 1;
      v = vt - 1;
      r.pix_tick = 1'b0;
    end else begin
      idx = (p - 1) % (ht * vt);
      h = idx % ht;
      v = idx / ht;
      r.pix_tick = ((ed % d) == 0);
    end
    r.frame_start = r.pix_tick && (h == 0) && (v == 0);
    r.video_on    = (h < hv) && (v < vv);
    r.h_sinc      = (h >= hv + hf && h < hv + hf + hs) ? act : ~act;
    r.v_sinc      = (v >= vv + vf && v < vv + vf + vs) ? act : ~act;
    r.h           = 11'(h);
    r.v           = 11'(v);
    return r;
  endfunction

  task automatic cmp(input string name, input exp_t act, input exp_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s e=%0d: got h=%0d v=%0d pt=%b fs=%b vid=%b hs=%b vs=%b, want h=%0d v=%0d pt=%b fs=%b vid=%b hs=%b vs=%b",
               name, e, act.h, act.v, act.pix_tick, act.frame_start, act.video_on, act.h_sinc,
               act.v_sinc, exp.h, exp.v, exp.pix_tick, exp.frame_start, exp.video_on,
               exp.h_sinc, exp.v_sinc);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_e(input int n);
    int guard = 0;
    while (e < n && guard < 50000) begin
      @(negedge clk);
      guard++;
    end
    chk($sformatf("reach_edge_%0d", n), e, n);
  endtask

  // Continuous model comparison, 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) e = 0;
      else e = e + 1;
      #1;
      cmp("cfg_a", act_a, model(e, 640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0));
      cmp("cfg_b", act_b, model(e, 16, 2, 4, 3, 10, 2, 2, 3, 1, 1'b1));
      cmp("cfg_c", act_c, model(e, 16, 2, 4, 3, 10, 2, 2, 3, 3, 1'b0));
    end
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_countH", int'(vga_a.countH), 799);
    chk("rst_countV", int'(vga_a.countV), 524);
    chk("rst_syncs", int'({vga_a.h_sinc, vga_a.v_sinc}), 3);
    chk("rst_flags", int'({vga_a.video_on, vga_a.pix_tick, vga_a.frame_start}), 0);
    reset = 1'b0;

    wait_e(1);
    chk("a_e1_pix_tick", int'(vga_a.pix_tick), 0);
    wait_e(2);
    chk("a_first_fs", int'({vga_a.frame_start, vga_a.pix_tick, vga_a.video_on}), 7);
    chk("a_first_pos", int'({vga_a.countH, vga_a.countV}), 0);
    chk("c_e2_pix_tick", int'(vga_c.pix_tick), 0);
    wait_e(3);
    chk("c_first_fs", int'(vga_c.frame_start), 1);
    chk("c_first_h", int'(vga_c.countH), 0);
    wait_e(19);
    chk("b_hs_on", int'(vga_b.h_sinc), 1);
    chk("b_h18", int'(vga_b.countH), 18);
    wait_e(22);
    chk("b_hs_last", int'(vga_b.h_sinc), 1);
    wait_e(23);
    chk("b_hs_off", int'(vga_b.h_sinc), 0);
    wait_e(300);
    chk("b_vs_before", int'(vga_b.v_sinc), 0);
    wait_e(301);
    chk("b_vs_on", int'(vga_b.v_sinc), 1);
    chk("b_v12", int'(vga_b.countV), 12);
    wait_e(425);
    chk("b_frame_end", int'({vga_b.countH, vga_b.countV}), (24 << 11) | 16);
    chk("b_frame_end_fs", int'(vga_b.frame_start), 0);
    wait_e(426);
    chk("b_frame_wrap_fs", int'(vga_b.frame_start), 1);
    chk("b_frame_wrap_pos", int'({vga_b.countH, vga_b.countV}), 0);
    wait_e(1281);
    chk("a_vid_639", int'(vga_a.video_on), 1);
    wait_e(1282);
    chk("a_vid_640", int'(vga_a.video_on), 0);
    chk("a_h640", int'(vga_a.countH), 640);
    wait_e(1313);
    chk("a_hs_655", int'(vga_a.h_sinc), 1);
    wait_e(1314);
    chk("a_hs_656", int'(vga_a.h_sinc), 0);
    wait_e(1505);
    chk("a_hs_751", int'(vga_a.h_sinc), 0);
    wait_e(1506);
    chk("a_hs_752", int'(vga_a.h_sinc), 1);
    chk("a_h752", int'(vga_a.countH), 752);
    wait_e(16000);
    chk("a_wrap_before", int'({vga_a.countH, vga_a.countV}), (799 << 11) | 9);
    wait_e(16002);
    chk("a_wrap_after", int'({vga_a.countH, vga_a.countV}), 10);
    wait_e(16642);
    chk("a_mid_pos", int'({vga_a.countH, vga_a.countV}), (320 << 11) | 10);

    // Asynchronous reset mid-frame: outputs must drop without a clock edge.
    reset = 1'b1;
    #1;
    chk("a_async_pos", int'({vga_a.countH, vga_a.countV}), (799 << 11) | 524);
    chk("a_async_syncs", int'({vga_a.h_sinc, vga_a.v_sinc}), 3);
    chk("a_async_vid", int'(vga_a.video_on), 0);
    chk("b_async_syncs", int'({vga_b.h_sinc, vga_b.v_sinc}), 0);
    chk("b_async_pos", int'({vga_b.countH, vga_b.countV}), (24 << 11) | 16);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_e(1);
    chk("a_restart_e1", int'(vga_a.pix_tick), 0);
    wait_e(2);
    chk("a_restart_fs", int'({vga_a.frame_start, vga_a.pix_tick, vga_a.video_on}), 7);
    chk("a_restart_pos", int'({vga_a.countH, vga_a.countV}), 0);
    wait_e(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
